bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles before preemption when another request is pending (legal 2..255).
REQ-002 Parameter: TURNAROUND, default 1, number of all-idle cycles between any two bus drivers (legal 1..15).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 Port: req  input  4  request lines; req[i]=1 means requester i wants the shared 16-bit tri-state bus.
REQ-006 Port: grant  output  4  registered one-hot tri-state enables; grant[i] drives enable of requester i's 16-bit tri-state buffer.
REQ-007 Port: owner  output  2  index of current or last granted requester.
REQ-008 Port: busy  output  1  high while in TURN or GRANT state.

Function
REQ-009 States: IDLE, TURN, GRANT; encoding free.
REQ-010 grant shall be 0000 or one-hot in every cycle; two bits set is a hard failure.
REQ-011 Arbitration: round-robin; search req starting at index ptr, ascending mod 4; first set bit wins.
REQ-012 IDLE, any req set: latch winner into owner, load turnaround counter, next state TURN; grant stays 0000.
REQ-013 IDLE, req=0000: remain IDLE, grant 0000, busy 0.
REQ-014 TURN: grant 0000 for exactly TURNAROUND cycles, then GRANT with grant[owner]=1 and hold counter cleared.
REQ-015 TURN, req[owner] drops before the final TURN cycle: abort to IDLE next cycle, no grant issued, ptr unchanged.
REQ-016 Latency: req sampled in IDLE at edge t -> grant asserted from edge t+1+TURNAROUND.
REQ-017 GRANT: hold counter increments each cycle, saturating at MAX_HOLD-1.
REQ-018 GRANT, req[owner]=0: release; ptr<=owner+1 mod 4; if other req pending, select next winner per REQ-011 and enter TURN, else IDLE; grant 0000 on next cycle.
REQ-019 GRANT, hold counter = MAX_HOLD-1 and any req[j], j!=owner, set: preempt, same transition as REQ-018 regardless of req[owner].
REQ-020 GRANT, sole requester at hold limit: keep grant, no gap, counter saturated.
REQ-021 Preempted requester still requesting competes normally; it shall not win again before other pending requesters under round-robin.
REQ-022 Consecutive grants to different requesters shall always be separated by >= TURNAROUND cycles of grant=0000.
REQ-023 busy = (state != IDLE), registered with state.

Reset
REQ-024 reset=0 at a rising edge: state IDLE, grant 0000, owner 00, ptr 00, busy 0, all counters 0, regardless of req or current state.
REQ-025 Reset during GRANT: grant shall read 0000 in the cycle after the reset edge; no partial release sequence.
REQ-026 First arbitration after reset release uses ptr=00.

Verification (TURNAROUND=1, MAX_HOLD=8)
REQ-027 reset=0 two cycles with req=1111 -> grant=0000, busy=0; release reset with req=0001 at edge t -> grant=0001 from edge t+2.
REQ-028 req=1111 from reset, each requester drops req 3 cycles after its grant -> grant sequence 0001,0000,0010,0000,0100,0000,1000, each grant 3 cycles.
REQ-029 req0 held continuously, req[2] raised during grant0 -> grant0 lasts exactly 8 cycles, one 0000 cycle, then grant=0100, owner=10.
REQ-030 req=0010 held 20 cycles alone -> grant=0010 continuous after initial 0000 turnaround, no gaps, busy=1 throughout.
REQ-031 req=0100 pulsed for exactly 1 cycle in IDLE -> TURN entered, abort to IDLE, grant never leaves 0000, ptr stays 00.
REQ-032 reset=0 mid-GRANT of requester 3 -> next cycle grant=0000, owner=00, busy=0; monitor confirms grant never has two bits set in any scenario.

Source files
------------

// File: rtl/bus_arbiter.sv
// Four-way round-robin arbiter for a shared tri-state bus.
// Registered one-hot enables, a turnaround gap between drivers and hold-limit preemption.
module bus_arbiter #(
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] owner,
    output logic       busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TURN  = 2'd1;
    localparam logic [1:0] S_GRANT = 2'd2;

    localparam logic [3:0] TA_LOAD  = 4'(TURNAROUND);
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    logic [1:0] r_state;
    logic [1:0] r_owner;
    logic [1:0] r_ptr;
    logic [3:0] r_grant;
    logic [3:0] r_cnt;
    logic [7:0] r_hold;
    logic       r_busy;

    logic [3:0] w_own_oh;
    logic [3:0] w_others;
    logic [1:0] w_next_ptr;
    logic [1:0] w_idle_win;
    logic [1:0] w_hand_win;
    logic       w_release;

    // First set bit of r found scanning upward from start, wrapping mod 4.
    function automatic logic [1:0] pick(input logic [3:0] r,
                                        input logic [1:0] start);
        logic [1:0] idx;
        pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    assign w_own_oh   = 4'b0001 << r_owner;
    assign w_others   = req & ~w_own_oh;
    assign w_next_ptr = r_owner + 2'd1;
    assign w_idle_win = pick(req, r_ptr);
    assign w_hand_win = pick(w_others, w_next_ptr);
    assign w_release  = !req[r_owner] ||
                        ((r_hold == HOLD_LIM) && (|w_others));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_owner <= 2'd0;
            r_ptr   <= 2'd0;
            r_grant <= 4'd0;
            r_cnt   <= 4'd0;
            r_hold  <= 8'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_owner <= w_idle_win;
                        r_cnt   <= TA_LOAD;
                        r_state <= S_TURN;
                        r_busy  <= 1'b1;
                    end
                end
                S_TURN: begin
                    if (!req[r_owner]) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt <= 4'd1) begin
                        r_state <= S_GRANT;
                        r_grant <= w_own_oh;
                        r_hold  <= 8'd0;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_grant <= 4'd0;
                        r_ptr   <= w_next_ptr;
                        r_hold  <= 8'd0;
                        if (|w_others) begin
                            r_owner <= w_hand_win;
                            r_cnt   <= TA_LOAD;
                            r_state <= S_TURN;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_hold != HOLD_LIM) begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 4'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign owner = r_owner;
    assign busy  = r_busy;

endmodule

// File: tb/tb_bus_arbiter.sv
// Random and directed stimulus for bus_arbiter against a cycle-level
// behavioural model of the arbitration rules.
module tb_bus_arbiter;

    localparam int T = 1;
    localparam int M = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = 4'd0;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;

    // Model: index being granted, index waiting out the gap, etc.
    int m_act  = -1;
    int m_pend = -1;
    int m_own  = 0;
    int m_ptr  = 0;
    int m_held = 0;
    int m_gap  = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_HOLD(M), .TURNAROUND(T)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .grant(grant),
        .owner(owner),
        .busy(busy)
    );

    function automatic int pick(logic [3:0] r, int start);
        for (int k = 0; k < 4; k++)
            if (r[(start + k) % 4]) return (start + k) % 4;
        return start;
    endfunction

    task automatic model_step(input logic rst_n, input logic [3:0] r);
        logic [3:0] others;
        if (!rst_n) begin
            m_act = -1; m_pend = -1; m_own = 0;
            m_ptr = 0; m_held = 0; m_gap = 0;
        end else if (m_act >= 0) begin
            others = r & ~(4'b0001 << m_act);
            if (!r[m_act] || (m_held >= M && others != 0)) begin
                m_ptr  = (m_act + 1) % 4;
                m_act  = -1;
                m_pend = -1;
                if (others != 0) begin
                    m_own  = pick(others, m_ptr);
                    m_pend = m_own;
                    m_gap  = T;
                end
            end else if (m_held < M) begin
                m_held++;
            end
        end else if (m_pend >= 0) begin
            if (!r[m_pend]) begin
                m_pend = -1;
            end else begin
                m_gap--;
                if (m_gap == 0) begin
                    m_act  = m_pend;
                    m_pend = -1;
                    m_held = 1;
                end
            end
        end else if (r != 0) begin
            m_own  = pick(r, m_ptr);
            m_pend = m_own;
            m_gap  = T;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b want %b", tag, $time, obs, exp);
        end
    endtask

    task automatic cyc(input logic rst_n, input logic [3:0] r);
        logic [3:0] exp_g;
        @(negedge clk);
        reset = rst_n;
        req   = r;
        @(posedge clk);
        model_step(rst_n, r);
        #1;
        exp_g = (m_act >= 0) ? (4'b0001 << m_act) : 4'd0;
        chk("grant", grant, exp_g);
        chk("owner", {2'b00, owner}, 4'(m_own));
        chk("busy", {3'b000, busy}, {3'b000, (m_act >= 0 || m_pend >= 0)});
        chk("onehot", {3'b000, $onehot0(grant)}, 4'd1);
    endtask

    initial begin
        logic [3:0] r;
        logic       rs;
        int         g0_len;

        // Reset with all requesting, then a lone requester 0.
        cyc(1'b0, 4'b1111);
        cyc(1'b0, 4'b1111);
        cyc(1'b0, 4'b0001);
        repeat (4) cyc(1'b1, 4'b0001);
        chk("lat_grant0", grant, 4'b0001);

        // All request; each drops three cycles into its grant.
        cyc(1'b0, 4'b0000);
        r = 4'b1111;
        repeat (24) begin
            if (m_act >= 0 && m_held == 3) r[m_act] = 1'b0;
            cyc(1'b1, r);
        end
        chk("rr_done", grant, 4'b0000);

        // Requester 0 holds; requester 2 joins and preempts at the limit.
        cyc(1'b0, 4'b0000);
        cyc(1'b1, 4'b0001);
        cyc(1'b1, 4'b0001);
        g0_len = 1;
        while (grant == 4'b0001 && g0_len < 40) begin
            cyc(1'b1, 4'b0101);
            if (grant == 4'b0001) g0_len++;
        end
        chk("hold_len", 4'(g0_len), 4'(M));
        cyc(1'b1, 4'b0101);
        chk("preempt_win", grant, 4'b0100);
        chk("preempt_own", {2'b00, owner}, 4'd2);
        repeat (3) cyc(1'b1, 4'b0101);

        // Sole requester keeps the bus past the hold limit.
        cyc(1'b0, 4'b0000);
        repeat (20) cyc(1'b1, 4'b0010);
        chk("sole_hold", grant, 4'b0010);

        // One-cycle pulse aborts in TURN; pointer still favours 0.
        cyc(1'b0, 4'b0000);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0100);
        repeat (3) cyc(1'b1, 4'b0000);
        repeat (3) cyc(1'b1, 4'b1111);
        chk("ptr_kept", grant, 4'b0001);

        // Reset in the middle of requester 3's grant.
        cyc(1'b0, 4'b0000);
        repeat (5) cyc(1'b1, 4'b1000);
        cyc(1'b0, 4'b1000);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_busy", {3'b000, busy}, 4'd0);

        // Random traffic with occasional resets.
        r = 4'b0000;
        repeat (800) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            rs = ($urandom_range(0, 60) != 0);
            cyc(rs, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
